// File: rtl/bit_serial_stream_driver.sv
// bit_serial_stream_driver: serializes parallel lane words LSB-first onto bit streams
// with start/window_done framing and a one-entry pending buffer for gap-free streaming.
module bit_serial_stream_driver #(
  parameter int N_LANES   = 256,
  parameter int WORD_BITS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_s_valid,
  output logic                         o_s_ready,
  input  logic [N_LANES*WORD_BITS-1:0] i_s_a_data,
  input  logic [N_LANES*WORD_BITS-1:0] i_s_b_data,
  input  logic                         i_s_first,
  input  logic                         i_s_last,
  input  logic                         i_hold,
  output logic [N_LANES-1:0]           o_weight_bits,
  output logic [N_LANES-1:0]           o_state_bits,
  output logic                         o_in_valid,
  output logic                         o_start,
  output logic                         o_window_done,
  output logic                         o_busy
);
  localparam int DW = N_LANES * WORD_BITS;
  localparam int BW = $clog2(WORD_BITS);
  typedef enum logic [1:0] {IDLE, START, STREAM} state_t;
  // Active slot holds the next item to emit; an idle slot is bypassed so an
  // accepted word appears on the outputs the cycle right after the accept edge.
  state_t          r_state;
  logic [BW-1:0]   r_bit_idx;
  logic [DW-1:0]   r_a, r_b, r_pa, r_pb;
  logic            r_last, r_pend_valid, r_pfirst, r_plast;
  logic            r_s_ready, r_in_valid, r_start, r_window_done, r_busy;
  logic [N_LANES-1:0] r_weight_bits, r_state_bits;
  logic            w_accept, w_bypass, w_cur_last, w_nlast;
  logic            w_emit, w_cur_end, w_finish, w_to_pend, w_npend, w_bit_out;
  state_t          w_cur_state, w_nstate;
  logic [BW-1:0]   w_cur_bit, w_nbit;
  logic [DW-1:0]   w_cur_a, w_cur_b, w_na, w_nb;
  logic [N_LANES-1:0] w_sel_a, w_sel_b;
  assign w_accept    = i_s_valid & r_s_ready;
  assign w_bypass    = (r_state == IDLE) & w_accept;
  assign w_cur_state = w_bypass ? (i_s_first ? START : STREAM) : r_state;
  assign w_cur_bit   = w_bypass ? '0 : r_bit_idx;
  assign w_cur_a     = w_bypass ? i_s_a_data : r_a;
  assign w_cur_b     = w_bypass ? i_s_b_data : r_b;
  assign w_cur_last  = w_bypass ? i_s_last : r_last;
  assign w_emit      = !i_hold && (w_cur_state != IDLE);
  assign w_cur_end   = (w_cur_state == STREAM) && (w_cur_bit == BW'(WORD_BITS - 1));
  assign w_finish    = w_emit & w_cur_end;
  assign w_to_pend   = w_accept & !w_bypass & !w_finish;
  assign w_npend     = !w_finish & (r_pend_valid | w_to_pend);
  assign w_bit_out   = w_emit && (w_cur_state == STREAM);
  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    logic [WORD_BITS-1:0] w_la, w_lb;
    assign w_la       = w_cur_a[g*WORD_BITS +: WORD_BITS];
    assign w_lb       = w_cur_b[g*WORD_BITS +: WORD_BITS];
    assign w_sel_a[g] = w_la[w_cur_bit];
    assign w_sel_b[g] = w_lb[w_cur_bit];
  end
  always_comb begin
    w_nstate = w_cur_state;
    w_nbit   = w_cur_bit;
    w_na     = w_cur_a;
    w_nb     = w_cur_b;
    w_nlast  = w_cur_last;
    if (w_finish) begin
      w_nstate = r_pend_valid ? (r_pfirst ? START : STREAM) : w_accept ? (i_s_first ? START : STREAM) : IDLE;
      w_nbit   = '0;
      w_na     = r_pend_valid ? r_pa : i_s_a_data;
      w_nb     = r_pend_valid ? r_pb : i_s_b_data;
      w_nlast  = r_pend_valid ? r_plast : i_s_last;
    end else if (w_emit && w_cur_state == START)
      w_nstate = STREAM;
    else if (w_emit)
      w_nbit = w_cur_bit + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_bit_idx     <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_last        <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pa          <= '0;
      r_pb          <= '0;
      r_pfirst      <= 1'b0;
      r_plast       <= 1'b0;
      r_s_ready     <= 1'b0;
      r_in_valid    <= 1'b0;
      r_start       <= 1'b0;
      r_window_done <= 1'b0;
      r_busy        <= 1'b0;
      r_weight_bits <= '0;
      r_state_bits  <= '0;
    end else begin
      r_state       <= w_nstate;
      r_bit_idx     <= w_nbit;
      r_a           <= w_na;
      r_b           <= w_nb;
      r_last        <= w_nlast;
      r_pend_valid  <= w_npend;
      if (w_to_pend) begin
        r_pa     <= i_s_a_data;
        r_pb     <= i_s_b_data;
        r_pfirst <= i_s_first;
        r_plast  <= i_s_last;
      end
      r_s_ready     <= !w_npend;
      r_in_valid    <= w_bit_out;
      r_start       <= w_emit && (w_cur_state == START);
      r_window_done <= w_finish && w_cur_last;
      r_busy        <= (w_nstate != IDLE) | w_npend | w_emit;
      r_weight_bits <= w_bit_out ? w_sel_a : '0;
      r_state_bits  <= w_bit_out ? w_sel_b : '0;
    end
  end
  assign o_s_ready     = r_s_ready;
  assign o_in_valid    = r_in_valid;
  assign o_start       = r_start;
  assign o_window_done = r_window_done;
  assign o_busy        = r_busy;
  assign o_weight_bits = r_weight_bits;
  assign o_state_bits  = r_state_bits;
endmodule

// File: doc/bit_serial_stream_driver.md
# bit_serial_stream_driver

- Transmit side of the bit-serial neuron array interface: accepts parallel lane words over a valid/ready handshake and serializes them LSB-first onto N_LANES bit streams.
- Generates the array's `in_valid` and `start` controls.
- Serves SNN mode (weight/spike streams) and HDC mode (hypervector A/B streams) identically.
- Sits between the weight/hypervector memory fetch logic and the neuron array; a one-entry pending buffer gives gap-free streaming across consecutive words.

## Interface
- N_LANES, 256: number of parallel lanes (neurons)
- WORD_BITS, 8: bits per lane per word; must be ≥ 2
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  input word valid
- s_ready  out  1  driver can accept a word
- s_a_data  in  N_LANES*WORD_BITS  stream A; lane i bit j = s_a_data[i*WORD_BITS+j]
- s_b_data  in  N_LANES*WORD_BITS  stream B; same packing
- s_first  in  1  word opens a new integration window; precede it with a start cycle
- s_last  in  1  word closes the window; pulse `window_done` after its final bit
- hold  in  1  freeze streaming: no bits emitted, no counter advance
- weight_bits  out  N_LANES  current bit of stream A per lane
- state_bits  out  N_LANES  current bit of stream B per lane
- in_valid  out  1  weight_bits/state_bits carry valid data this cycle
- start  out  1  one-cycle window-start pulse; always with in_valid=0
- window_done  out  1  one-cycle pulse coincident with final bit of an s_last word
- busy  out  1  active or pending word present

## Operation
- Storage:
  - active slot: A/B words, first/last flags, and bit counter `bit_idx` (0..WORD_BITS-1).
  - pending slot: A/B words and flags.
- Handshake:
  - Accept when s_valid && s_ready.
  - s_ready = !pend_valid (registered-state-derived; no combinational dependence on s_valid).
- Load rules on accept:
  - Accepted word goes directly to active if active is empty, or active is finishing its last bit this cycle without hold, and pending is empty.
  - Otherwise it goes to pending.
  - Pending moves to active when active finishes its last bit.
- FSM states (active slot):
  - IDLE: no active word.
  - START: one cycle; drives start=1, in_valid=0.
  - STREAM: drives in_valid=1 and emits bit `bit_idx` of each lane.
- Transitions:
  - IDLE/finish → START if the loaded word has first=1, else → STREAM with bit_idx=0.
  - STREAM with bit_idx=WORD_BITS-1 and !hold: if another word is available → START/STREAM; else → IDLE.
- hold=1:
  - in_valid=0, start=0, window_done=0.
  - State, bit_idx and slots frozen.
  - Deferred START/bits resume unchanged the cycle after hold deasserts.
  - Accepts still occur if s_ready=1.
- Bit outputs:
  - weight_bits[i] = A[i*WORD_BITS+bit_idx], state_bits[i] = B[i*WORD_BITS+bit_idx].
  - Both are 0 whenever in_valid=0.
- window_done = 1 when emitting bit WORD_BITS-1 of a word with last=1.
- busy = active_valid | pend_valid.

## Timing
- All outputs are registered.
- Reset values:
  - s_ready=0 while rst_n low, 1 in the first cycle after release.
  - in_valid=0, start=0, window_done=0, busy=0, weight_bits=0, state_bits=0.
- Latency: accept at edge E → first output (start or bit 0) in the cycle following E.
- Word duration:
  - WORD_BITS cycles without first.
  - WORD_BITS+1 cycles with first.
  - Each hold cycle adds one cycle.
- Back-to-back: with pending full at finish, the next word's START or bit 0 follows the previous bit WORD_BITS-1 with zero bubble.
- Throughput: one word per WORD_BITS(+1) cycles; s_ready deasserts while pending is occupied.
- Reset mid-word:
  - Both slots are discarded immediately (asynchronous).
  - Outputs go to reset values.
  - No partial window_done is emitted.
- s_first and s_last both set on one word: start precedes the bits, and window_done fires on the final bit.

## Test plan
- Single word, WORD_BITS=8, N_LANES=4, first=1, lane0 A=0xA5, B=0x0F:
  - Expect start=1 one cycle after accept.
  - Then 8 in_valid cycles; lane0 weight_bits = 1,0,1,0,0,1,0,1 and state_bits = 1,1,1,1,0,0,0,0.
- Three words offered back-to-back, first only on word 0, last on word 2:
  - Expect s_ready low while pending full.
  - Expect exactly 25 contiguous cycles (1 start + 24 bits) with no gap.
  - window_done on cycle 25 only.
- hold asserted for 3 cycles after bit 3 of a word:
  - Expect in_valid=0 for those 3 cycles.
  - Then bit 4 resumes; total duration 3 cycles longer; data unchanged.
- hold asserted during the START cycle:
  - Expect start deferred until hold deasserts.
  - Exactly one start pulse, bits follow.
- rst_n pulsed low at bit 5 with a pending word:
  - Expect all outputs 0 immediately, busy=0, no window_done.
  - s_ready=1 after release; a subsequent word streams correctly from bit 0.
- Word with first=1 and last=1, WORD_BITS=2:
  - Expect start, bit0, bit1 + window_done; then busy=0 the next cycle.
